rbm_vote_argmax: RTL and testbench

Host-side driver and result reader for the RBM classifier top level. It accepts one input sample over a valid/ready handshake and holds the classifier in reset until the sample is latched. It then releases the classifier, waits for its `finish`, and captures the per-class vote counters. A serial arg-max scan reduces those counters to a class label, which is presented on a second valid/ready handshake.

---
 rtl/rbm_vote_argmax.sv | 192 +++++++++++++++++++
 tb/tb_rbm_vote_argmax.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rbm_vote_argmax.sv
// Host-side driver for the RBM classifier: latches a sample, runs the classifier,
// then reduces the captured per-class vote counters to a label with a serial arg-max.
module rbm_vote_argmax #(
    parameter int bitlength      = 12,
    parameter int input_dim      = 784,
    parameter int output_dim     = 10,
    parameter int label_width    = 4,
    parameter int timeout_cycles = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    input  logic [input_dim-1:0]            sample_data,
    output logic                            rbm_reset,
    output logic                            rbm_data_valid,
    output logic [input_dim-1:0]            rbm_data,
    input  logic                            rbm_finish,
    input  logic [output_dim*bitlength-1:0] rbm_votes,
    output logic                            label_valid,
    input  logic                            label_ready,
    output logic [label_width-1:0]          label,
    output logic [bitlength-1:0]            max_votes,
    output logic                            label_tie,
    output logic                            label_error
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SCAN, HOLD} state_t;

    localparam logic [label_width-1:0] LAST = label_width'(output_dim - 1);
    localparam logic [31:0]            TMO  = 32'(timeout_cycles);

    typedef logic [output_dim-1:0][bitlength-1:0] votes_t;

    state_t                 state_q, state_d;
    logic                   sample_ready_q, sample_ready_d;
    logic                   rbm_reset_q, rbm_reset_d;
    logic                   rbm_dv_q, rbm_dv_d;
    logic [input_dim-1:0]   rbm_data_q, rbm_data_d;
    votes_t                 votes_q, votes_d;
    logic [label_width-1:0] idx_q, idx_d;
    logic [31:0]            tmo_q, tmo_d;
    logic [label_width-1:0] best_idx_q, best_idx_d;
    logic [bitlength-1:0]   best_val_q, best_val_d;
    logic                   tie_q, tie_d;
    logic                   label_valid_q, label_valid_d;
    logic [label_width-1:0] label_q, label_d;
    logic [bitlength-1:0]   max_votes_q, max_votes_d;
    logic                   label_tie_q, label_tie_d;
    logic                   label_error_q, label_error_d;

    logic [bitlength-1:0]   cur_v;
    logic [label_width-1:0] nb_idx;
    logic [bitlength-1:0]   nb_val;
    logic                   nb_tie;

    // One arg-max step: equal votes keep the lower index and flag a tie.
    always_comb begin
        cur_v  = votes_q[idx_q];
        nb_idx = best_idx_q;
        nb_val = best_val_q;
        nb_tie = tie_q;
        if (idx_q == '0) begin
            nb_idx = '0;
            nb_val = cur_v;
            nb_tie = 1'b0;
        end else if (cur_v > best_val_q) begin
            nb_idx = idx_q;
            nb_val = cur_v;
            nb_tie = 1'b0;
        end else if (cur_v == best_val_q) begin
            nb_tie = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rbm_data_d    = rbm_data_q;
        votes_d       = votes_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        best_idx_d    = best_idx_q;
        best_val_d    = best_val_q;
        tie_d         = tie_q;
        label_valid_d = label_valid_q;
        label_d       = label_q;
        max_votes_d   = max_votes_q;
        label_tie_d   = label_tie_q;
        label_error_d = label_error_q;
        unique case (state_q)
            IDLE: begin
                if (sample_valid && sample_ready_q) begin
                    rbm_data_d = sample_data;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 32'd1;
                if (rbm_finish) begin
                    votes_d = rbm_votes;
                    idx_d   = '0;
                    state_d = SCAN;
                end else if (TMO != '0 && tmo_q == TMO) begin
                    label_d       = '0;
                    max_votes_d   = '0;
                    label_tie_d   = 1'b0;
                    label_error_d = 1'b1;
                    label_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            SCAN: begin
                best_idx_d = nb_idx;
                best_val_d = nb_val;
                tie_d      = nb_tie;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    label_d       = nb_idx;
                    max_votes_d   = nb_val;
                    label_tie_d   = nb_tie;
                    label_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (label_valid_q && label_ready) begin
                    label_valid_d = 1'b0;
                    label_error_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake/control outputs follow the state being entered.
        sample_ready_d = (state_d == IDLE);
        rbm_reset_d    = (state_d != WAIT);
        rbm_dv_d       = (state_d == WAIT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sample_ready_q <= 1'b0;
            rbm_reset_q    <= 1'b1;
            rbm_dv_q       <= 1'b0;
            rbm_data_q     <= '0;
            votes_q        <= '0;
            idx_q          <= '0;
            tmo_q          <= '0;
            best_idx_q     <= '0;
            best_val_q     <= '0;
            tie_q          <= 1'b0;
            label_valid_q  <= 1'b0;
            label_q        <= '0;
            max_votes_q    <= '0;
            label_tie_q    <= 1'b0;
            label_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_ready_q <= sample_ready_d;
            rbm_reset_q    <= rbm_reset_d;
            rbm_dv_q       <= rbm_dv_d;
            rbm_data_q     <= rbm_data_d;
            votes_q        <= votes_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            best_idx_q     <= best_idx_d;
            best_val_q     <= best_val_d;
            tie_q          <= tie_d;
            label_valid_q  <= label_valid_d;
            label_q        <= label_d;
            max_votes_q    <= max_votes_d;
            label_tie_q    <= label_tie_d;
            label_error_q  <= label_error_d;
        end
    end

    assign sample_ready   = sample_ready_q;
    assign rbm_reset      = rbm_reset_q;
    assign rbm_data_valid = rbm_dv_q;
    assign rbm_data       = rbm_data_q;
    assign label_valid    = label_valid_q;
    assign label          = label_q;
    assign max_votes      = max_votes_q;
    assign label_tie      = label_tie_q;
    assign label_error    = label_error_q;

endmodule

// File: tb/tb_rbm_vote_argmax.sv
// Scoreboard bench for rbm_vote_argmax with a stub classifier
// and an arg-max reference model.
module tb_rbm_vote_argmax;

    localparam int BL = 12;
    localparam int ID = 784;
    localparam int OD = 10;
    localparam int LW = 4;
    localparam int TO = 20;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic [ID-1:0]    sample_data = '0;
    logic             rbm_reset;
    logic             rbm_data_valid;
    logic [ID-1:0]    rbm_data;
    logic             rbm_finish = 1'b0;
    logic [OD*BL-1:0] rbm_votes = '0;
    logic             label_valid;
    logic             label_ready = 1'b1;
    logic [LW-1:0]    label;
    logic [BL-1:0]    max_votes;
    logic             label_tie;
    logic             label_error;

    rbm_vote_argmax #(
        .bitlength(BL), .input_dim(ID), .output_dim(OD),
        .label_width(LW), .timeout_cycles(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data),
        .rbm_reset(rbm_reset), .rbm_data_valid(rbm_data_valid),
        .rbm_data(rbm_data), .rbm_finish(rbm_finish),
        .rbm_votes(rbm_votes),
        .label_valid(label_valid), .label_ready(label_ready),
        .label(label), .max_votes(max_votes),
        .label_tie(label_tie), .label_error(label_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [LW-1:0] lab;
        logic [BL-1:0] mx;
        logic          tie;
        logic          err;
    } res_t;

    res_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: largest value, lowest index holding it, tie if held more than once.
    function automatic res_t model(input int unsigned a[OD]);
        res_t r;
        int unsigned m = 0;
        int first = -1;
        int cnt = 0;
        foreach (a[i]) if (a[i] > m) m = a[i];
        foreach (a[i]) begin
            if (a[i] == m) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        r.lab = LW'(first);
        r.mx  = BL'(m);
        r.tie = (cnt > 1);
        r.err = 1'b0;
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset && label_valid && label_ready) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_label: got label %0d with empty scoreboard", label);
            end else begin
                res_t e;
                e = expq.pop_front();
                chk("label", 32'(label), 32'(e.lab));
                chk("max_votes", 32'(max_votes), 32'(e.mx));
                chk("label_tie", 32'(label_tie), 32'(e.tie));
                chk("label_error", 32'(label_error), 32'(e.err));
            end
        end
    end

    logic [ID-1:0] smp;

    task automatic new_sample();
        for (int i = 0; i < ID; i += 32) smp[i +: 16] = 16'($urandom);
        for (int i = 16; i < ID; i += 32) smp[i +: 16] = 16'($urandom);
        sample_data = smp;
    endtask

    task automatic set_votes(input int unsigned a[OD]);
        for (int i = 0; i < OD; i++) rbm_votes[i*BL +: BL] = BL'(a[i]);
    endtask

    task automatic accept(input bit quick, output int e);
        if (!quick) begin
            int g = 0;
            sample_valid = 1'b1;
            while (!sample_ready && g < 200) begin
                @(posedge clock); #1; g++;
            end
            chk("sample_ready_wait", 32'(sample_ready), 1);
        end else begin
            chk("sample_ready_at_H", 32'(sample_ready), 1);
        end
        @(posedge clock); #1;
        sample_valid = 1'b0;
        chk("rbm_data_latched", 32'(rbm_data == smp), 1);
        chk("rbm_reset_launch", 32'(rbm_reset), 1);
        chk("dv_launch", 32'(rbm_data_valid), 0);
        @(posedge clock); #1;
        e = cyc;
        chk("rbm_reset_wait", 32'(rbm_reset), 0);
        chk("dv_wait", 32'(rbm_data_valid), 1);
    endtask

    // d < 0: classifier never finishes; otherwise finish is first sampled d+1 edges after WAIT entry.
    task automatic run(input int unsigned a[OD], input int d, input bit quick, input bit bp);
        int e, c, rise, g;
        res_t r;
        if (!quick) new_sample();
        set_votes(a);
        accept(quick, e);
        if (d < 0) begin
            r = '{lab: '0, mx: '0, tie: 1'b0, err: 1'b1};
            rise = e + TO + 1;
        end else begin
            r = model(a);
            repeat (d) begin @(posedge clock); #1; end
            rbm_finish = 1'b1;
            c = cyc + 1;
            rise = c + OD;
        end
        expq.push_back(r);
        if (bp) label_ready = 1'b0;
        g = 0;
        while (!label_valid && g < 200) begin
            @(posedge clock); #1; g++;
        end
        chk("label_valid_seen", 32'(label_valid), 1);
        chk("label_valid_rise_cycle", 32'(cyc), 32'(rise));
        chk("rbm_reset_after_wait", 32'(rbm_reset), 1);
        rbm_finish = 1'b0;
        if (!bp) begin
            @(posedge clock); #1;
            chk("label_valid_one_cycle", 32'(label_valid), 0);
        end else begin
            logic [31:0] snap;
            logic [ID-1:0] held;
            snap = 32'({label_valid, label_error, label_tie, max_votes, label});
            held = rbm_data;
            new_sample();
            sample_valid = 1'b1;
            repeat (15) begin
                @(posedge clock); #1;
                chk("bp_result_stable",
                    32'({label_valid, label_error, label_tie, max_votes, label}), snap);
                chk("bp_sample_ready", 32'(sample_ready), 0);
                chk("bp_data_not_consumed", 32'(rbm_data == held), 1);
            end
            label_ready = 1'b1;
            @(posedge clock); #1;
            chk("bp_valid_drop_H", 32'(label_valid), 0);
            chk("bp_sample_ready_H", 32'(sample_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned a[OD];
        int e;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rbm_reset", 32'(rbm_reset), 1);
        chk("rst_sample_ready", 32'(sample_ready), 0);
        chk("rst_dv", 32'(rbm_data_valid), 0);
        chk("rst_label_valid", 32'(label_valid), 0);
        chk("rst_tie_err", 32'({label_tie, label_error}), 0);
        chk("rst_label_max", 32'({label, max_votes}), 0);
        chk("rst_rbm_data", 32'(rbm_data == '0), 1);
        reset = 1'b1;

        a = '{3, 7, 1, 0, 9, 2, 0, 0, 5, 4};
        run(a, 4, 0, 0);
        a = '{0, 6, 0, 6, 0, 0, 0, 0, 0, 0};
        run(a, 0, 0, 0);
        a = '{5, 5, 8, 0, 0, 0, 0, 0, 0, 0};
        run(a, 7, 0, 0);
        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run(a, 2, 0, 0);
        a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 4095};
        run(a, 1, 0, 0);
        a = '{4095, 4094, 0, 4095, 1, 2, 3, 4, 5, 6};
        run(a, 3, 0, 0);
        // finish sampled on the same edge the timeout would fire
        a = '{2, 9, 9, 1, 0, 0, 0, 0, 0, 11};
        run(a, TO, 0, 0);
        run(a, -1, 0, 0);
        a = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
        run(a, 5, 0, 1);
        a = '{0, 0, 0, 7, 0, 0, 0, 0, 0, 0};
        run(a, 2, 1, 0);

        new_sample();
        a = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        set_votes(a);
        accept(0, e);
        repeat (3) begin @(posedge clock); #1; end
        #2 reset = 1'b0;
        #1;
        chk("midrst_rbm_reset", 32'(rbm_reset), 1);
        chk("midrst_dv", 32'(rbm_data_valid), 0);
        chk("midrst_label_valid", 32'(label_valid), 0);
        chk("midrst_sample_ready", 32'(sample_ready), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        a = '{0, 3, 12, 12, 1, 0, 0, 0, 0, 0};
        run(a, 6, 0, 0);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < OD; i++)
                a[i] = $urandom_range(0, (k % 2) ? 3 : 4095);
            run(a, $urandom_range(0, 15), 0, 0);
        end

        repeat (3) @(posedge clock);
        chk("scoreboard_drained", 32'(expq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
